// File: rtl/universal_pkg.sv
// Shared types for the universal shift register: per-cell next-state selection.
// Combinational helper only; no latency, no backpressure.
package universal_pkg;

  typedef enum logic [1:0] {
    MODE_LOAD    = 2'd0,
    MODE_FROM_HI = 2'd1,
    MODE_FROM_LO = 2'd2
  } cell_mode_e;

  // Reset doubles as the parallel-load strobe, so it outranks direction.
  function automatic cell_mode_e cell_mode(input logic reset, input logic sel);
    if (reset) return MODE_LOAD;
    if (sel)   return MODE_FROM_HI;
    return MODE_FROM_LO;
  endfunction

endpackage

// File: rtl/universal_cell.sv
// One bit of the universal shift register: a flop behind a load/left/right mux.
// Latency 1 clk; no backpressure (updates every edge).
module universal_cell
  import universal_pkg::*;
(
  input  logic       clk,
  input  cell_mode_e mode,
  input  logic       load,
  input  logic       from_hi,
  input  logic       from_lo,
  output logic       q
);

  always_ff @(posedge clk) begin
    case (mode)
      MODE_LOAD:    q <= load;
      MODE_FROM_HI: q <= from_hi;
      default:      q <= from_lo;
    endcase
  end

endmodule

// File: rtl/universal.sv
// Universal shift register: parallel load on reset, else shift right (sel=1) or left (sel=0).
// Latency 1 clk from sampled inputs to out; no backpressure, shifts every cycle.
module universal
  import universal_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic [WIDTH-1:0] in_load,
  input  logic             in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] hi_src;
  logic [WIDTH-1:0] lo_src;
  cell_mode_e       mode;

  // Neighbour vectors: serial bit enters the MSB on a right shift, the LSB on a left shift.
  assign hi_src = {in, q[WIDTH-1:1]};
  assign lo_src = {q[WIDTH-2:0], in};
  assign mode   = cell_mode(reset, sel);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    universal_cell u_cell (
      .clk     (clk),
      .mode    (mode),
      .load    (in_load[i]),
      .from_hi (hi_src[i]),
      .from_lo (lo_src[i]),
      .q       (q[i])
    );
  end

  assign out = q;

endmodule

// File: tb/tb_universal.sv
// Scoreboard bench for universal: stimulus pushes expected values, a monitor pops after each edge.
module tb_universal;

  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         sel;
  logic [W-1:0] in_load;
  logic         in;
  logic [W-1:0] out;

  int errors = 0;
  int checks = 0;
  int model  = 0;
  bit stim_done = 0;

  logic [W-1:0] exp_q[$];
  string        name_q[$];

  universal #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .sel     (sel),
    .in_load (in_load),
    .in      (in),
    .out     (out)
  );

  always #5 clk = ~clk;

  // Reference behaviour written as integer arithmetic on the register value.
  function automatic int ref_next(int cur, bit r, bit s, int ld, bit b);
    if (r)      return ld & MASK;
    if (s)      return (cur >> 1) | (int'(b) << (W - 1));
    return ((cur << 1) | int'(b)) & MASK;
  endfunction

  // Drive one cycle of inputs; lit >= 0 overrides the model with a hand-derived value.
  task automatic step(input bit r, input bit s, input bit b, input int ld,
                      input string nm, input int lit, input bit wiggle);
    reset   = r;
    sel     = s;
    in      = b;
    in_load = ld[W-1:0];
    model   = (lit >= 0) ? lit : ref_next(model, r, s, ld, b);
    exp_q.push_back(model[W-1:0]);
    name_q.push_back(nm);
    if (wiggle) begin
      #2 in_load = W'($urandom);
      #1 in_load = W'($urandom);
    end
    @(negedge clk);
  endtask

  // Monitor: compare one expected value just after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [W-1:0] e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (out !== e) begin
          errors++;
          $display("FAIL %s: out=%b expected=%b", nm, out, e);
        end
      end
    end
  end

  initial begin
    // Directed sequence with hand-derived literals.
    step(1, 0, 0, 4'b0000, "rst_zero",      4'b0000, 0);
    step(1, 1, 1, 4'b0000, "rst_hold",      4'b0000, 0);
    step(1, 1, 1, 4'b1010, "load_1010",     4'b1010, 0);
    step(0, 1, 1, 4'b0000, "shr_in1",       4'b1101, 0);
    step(0, 1, 0, 4'b1111, "shr_in0",       4'b0110, 0);
    step(0, 0, 1, 4'b0000, "shl_in1",       4'b1101, 0);
    step(0, 0, 0, 4'b0101, "shl_in0",       4'b1010, 0);
    step(0, 0, 1, 4'b0000, "fill1_a",       4'b0101, 0);
    step(0, 0, 1, 4'b0000, "fill1_b",       4'b1011, 0);
    step(0, 0, 1, 4'b0000, "fill1_c",       4'b0111, 0);
    step(0, 0, 1, 4'b0000, "fill1_d",       4'b1111, 0);
    step(0, 1, 0, 4'b1111, "drain0_a",      4'b0111, 0);
    step(0, 1, 0, 4'b1111, "drain0_b",      4'b0011, 0);
    step(0, 1, 0, 4'b1111, "drain0_c",      4'b0001, 0);
    step(0, 1, 0, 4'b1111, "drain0_d",      4'b0000, 0);
    step(1, 0, 0, 4'b0110, "load_0110",     4'b0110, 0);
    step(1, 1, 1, 4'b0011, "rst_midshift",  4'b0011, 0);
    step(0, 0, 0, 4'b1111, "ld_ignored_a",  4'b0110, 1);
    step(0, 1, 1, 4'b0000, "ld_ignored_b",  4'b1011, 1);
    step(1, 0, 0, 4'b1011, "hold_by_load",  4'b1011, 0);

    // Randomized phase: mostly shifting, occasional loads, in_load noise between edges.
    for (int k = 0; k < 300; k++) begin
      bit r;
      r = ($urandom_range(0, 7) == 0);
      step(r, 1'($urandom), 1'($urandom), int'($urandom_range(0, MASK)),
           r ? "rand_load" : "rand_shift", -1, !r);
    end
    stim_done = 1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!stim_done && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!stim_done || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: stim_done=%0d pending=%0d expected done with 0 pending",
               stim_done, exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/universal.md
UNIVERSAL -- requirements
Module: universal

Interface
REQ-001 Parameter: WIDTH, default 4, register width in bits; legal range WIDTH >= 2.
REQ-002 The port list SHALL be exactly as follows, in this order.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high; acts as parallel-load strobe, sampled only at the rising edge of clk.
REQ-005 sel  input  1  shift direction: 1 = shift right (toward bit 0), 0 = shift left (toward MSB).
REQ-006 in_load  input  WIDTH  parallel-load value, captured while reset=1.
REQ-007 in  input  1  serial data bit entering the vacated end on each shift.
REQ-008 out  output  WIDTH  registered contents of the shift register, driven directly from flops.

Function
REQ-009 The block SHALL hold one WIDTH-bit state register q, with out = q at all times and no combinational path from any input to out.
REQ-010 At each rising edge of clk with reset=1, q SHALL load in_load; sel and in are ignored that cycle.
REQ-011 At each rising edge with reset=0 and sel=1, q SHALL become {in, q[WIDTH-1:1]}: in enters the MSB, and q[0] is discarded.
REQ-012 At each rising edge with reset=0 and sel=0, q SHALL become {q[WIDTH-2:0], in}: in enters the LSB, and q[WIDTH-1] is discarded.
REQ-013 The block SHALL shift every cycle while reset=0; no hold mode exists, so holding a value requires asserting reset with in_load equal to q.
REQ-014 Latency: out SHALL reflect the new value one clock edge after the controlling inputs are sampled.
REQ-015 Changes to in_load while reset=0 SHALL have no effect on q.
REQ-016 Changes to sel or in between clock edges SHALL have no effect; only values present at the rising edge matter.
REQ-017 The discarded end bit on any shift SHALL be lost; the block has no serial-out port or carry.
REQ-018 A sel change SHALL take effect on the very edge that samples it, with no turnaround cycle.
REQ-019 Before the first reset edge, q SHALL be X in simulation; no initial value is defined.

Reset
REQ-020 Reset SHALL be synchronous and active-high, with no asynchronous path.
REQ-021 The reset value of out SHALL be the value of in_load sampled at the resetting edge, e.g. 0000 when in_load=0000.
REQ-022 Reset asserted mid-operation SHALL override any shift on that edge.
REQ-023 Reset held for multiple cycles SHALL track in_load on every edge.

Structure
REQ-024 No shared package is required; WIDTH is the only parameter and lives in the module header.
REQ-025 One sub-module is natural: universal_cell, a 1-bit flop with a 3-input next-state mux (load / left neighbour / right neighbour).
REQ-026 The top level SHALL generate WIDTH instances of universal_cell, feeding the end cells from in.
REQ-027 A single always block implementation is also acceptable, provided REQ-009 to REQ-023 hold.

Verification
REQ-028 Reset with in_load=0000, then hold reset=1 for 1 edge -> out=0000.
REQ-029 reset=1 with in_load=1010, 1 edge -> out=1010; then reset=0, sel=1, in=1 -> 1101; then sel=1, in=0 -> 0110.
REQ-030 From 0110, sel=0, in=1 -> 1101; then sel=0, in=0 -> 1010.
REQ-031 From 1010, apply 4 edges of sel=0, in=1 -> 1111; then 4 edges of sel=1, in=0 -> 0000.
REQ-032 Reset mid-shift: from 0110, raise reset=1 with in_load=0011 and sel=1 on the same edge -> out=0011, no shift.
REQ-033 in_load toggled between edges while reset=0 -> out unchanged by in_load; only shifting occurs.
